// File: rtl/ram_arb_dp_if.sv
// Request/response bundle between the fetch/LSU requesters and ram_arb_dp.
// Signal suffixes are taken from the RAM's point of view (slave modport).
interface ram_arb_dp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_err_o;

   logic              ls_req_i;
   logic              ls_we_i;
   logic [BE_W-1:0]   ls_be_i;
   logic [ADDR_W-1:0] ls_addr_i;
   logic [DATA_W-1:0] ls_wdata_i;
   logic              ls_gnt_o;
   logic              ls_rvalid_o;
   logic [DATA_W-1:0] ls_rdata_o;
   logic              ls_err_o;

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
      output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
      input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o
   );

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
      input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
      output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o
   );
endinterface

// File: rtl/ram_arb_dp.sv
// Single-ported data RAM shared by instruction fetch and LSU, with starvation-free
// arbitration and 1-cycle registered read. Define RAM_BOUNDS_CHECK_EN for range errors.
module ram_arb_dp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 32
) (
   input logic         clk_i,
   input logic         n_rst_i,
   ram_arb_dp_if.slave bus
);
   localparam int BE_W   = DATA_W / 8;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int IDX_LO = $clog2(BE_W);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   logic starve_q, starve_d;
   logic if_rvalid_q, if_rvalid_d;
   logic ls_rvalid_q, ls_rvalid_d;
   logic ls_rd_q, ls_rd_d;
   logic if_err_q, if_err_d;
   logic ls_err_q, ls_err_d;

   logic              if_gnt, ls_gnt;
   logic [ADDR_W-1:0] acc_addr;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_oor;
   logic              wr_en, rd_en;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{bus.if_addr_i, bus.ls_addr_i};

   // LSU wins a collision unless IF was refused last time it asked
   always_comb begin
      ls_gnt   = bus.ls_req_i & (~bus.if_req_i | ~starve_q);
      if_gnt   = bus.if_req_i & (~bus.ls_req_i | starve_q);
      acc_addr = ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
      acc_idx  = acc_addr[IDX_LO +: IDX_W];
   end

`ifdef RAM_BOUNDS_CHECK_EN
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * BE_W);
   assign acc_oor = ({1'b0, acc_addr} >= ADDR_LIMIT);
`else
   assign acc_oor = 1'b0;
`endif

   always_comb begin
      wr_en       = ls_gnt & bus.ls_we_i & ~acc_oor;
      rd_en       = (if_gnt | (ls_gnt & ~bus.ls_we_i)) & ~acc_oor;
      starve_d    = starve_q;
      if (if_gnt)
         starve_d = 1'b0;
      else if (bus.if_req_i)
         starve_d = 1'b1;
      if_rvalid_d = if_gnt;
      ls_rvalid_d = ls_gnt;
      ls_rd_d     = ls_gnt & ~bus.ls_we_i;
      if_err_d    = if_gnt & acc_oor;
      ls_err_d    = ls_gnt & acc_oor;
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         starve_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         ls_rd_q     <= 1'b0;
         if_err_q    <= 1'b0;
         ls_err_q    <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         ls_rd_q     <= ls_rd_d;
         if_err_q    <= if_err_d;
         ls_err_q    <= ls_err_d;
      end
   end

   // Storage and read register carry no reset; outputs are masked by rvalid instead
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < BE_W; k++) begin
            if (bus.ls_be_i[k])
               mem[acc_idx][8*k +: 8] <= bus.ls_wdata_i[8*k +: 8];
         end
      end
      if (rd_en)
         rdata_q <= mem[acc_idx];
   end

   assign bus.if_gnt_o    = if_gnt;
   assign bus.ls_gnt_o    = ls_gnt;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.ls_rvalid_o = ls_rvalid_q;
   assign bus.if_err_o    = if_rvalid_q & if_err_q;
   assign bus.ls_err_o    = ls_rvalid_q & ls_err_q;
   assign bus.if_rdata_o  = (if_rvalid_q & ~if_err_q) ? rdata_q : '0;
   assign bus.ls_rdata_o  = (ls_rvalid_q & ls_rd_q & ~ls_err_q) ? rdata_q : '0;
endmodule

// File: tb/tb_ram_arb_dp.sv
// Directed bench for ram_arb_dp; expectations follow RAM_BOUNDS_CHECK_EN when defined.
module tb_ram_arb_dp;
   logic clk_i   = 1'b0;
   logic n_rst_i = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   ram_arb_dp_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   ram_arb_dp #(.DATA_W(32), .DEPTH(4096), .ADDR_W(32)) dut (
      .clk_i   (clk_i),
      .n_rst_i (n_rst_i),
      .bus     (bus.slave)
   );

   always #5 clk_i = ~clk_i;

`ifdef RAM_BOUNDS_CHECK_EN
   localparam logic        BND_ERR   = 1'b1;
   localparam logic [31:0] WORD0_EXP = 32'h1234_5678;
`else
   localparam logic        BND_ERR   = 1'b0;
   localparam logic [31:0] WORD0_EXP = 32'hCAFE_F00D;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bus.if_req_i   = 1'b0;
      bus.ls_req_i   = 1'b0;
      bus.ls_we_i    = 1'b0;
      bus.ls_be_i    = 4'h0;
   endtask

   task automatic ls_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = 1'b1;
      bus.ls_addr_i  = addr;
      bus.ls_wdata_i = data;
      bus.ls_be_i    = be;
   endtask

   task automatic ls_read(input logic [31:0] addr);
      bus.ls_req_i  = 1'b1;
      bus.ls_we_i   = 1'b0;
      bus.ls_addr_i = addr;
      bus.ls_be_i   = 4'h0;
   endtask

   initial begin
      bus.if_addr_i  = '0;
      bus.ls_addr_i  = '0;
      bus.ls_wdata_i = '0;
      idle();

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_if_rvalid", {31'b0, bus.if_rvalid_o}, 32'h0);
      chk("rst_ls_rvalid", {31'b0, bus.ls_rvalid_o}, 32'h0);
      chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
      chk("rst_ls_rdata", bus.ls_rdata_o, 32'h0);
      chk("rst_errs", {30'b0, bus.if_err_o, bus.ls_err_o}, 32'h0);
      n_rst_i = 1'b1;

      // First IF-only request granted at once
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0;
      #1;
      chk("first_if_gnt", {30'b0, bus.if_gnt_o, bus.ls_gnt_o}, 32'h2);
      tick();
      bus.if_req_i = 1'b0;
      chk("first_if_rvalid", {31'b0, bus.if_rvalid_o}, 32'h1);
      tick();
      chk("if_rvalid_single", {31'b0, bus.if_rvalid_o}, 32'h0);

      // Byte enables
      ls_write(32'h10, 32'hDEAD_BEEF, 4'hF);
      #1;
      chk("wr_gnt", {30'b0, bus.if_gnt_o, bus.ls_gnt_o}, 32'h1);
      tick();
      chk("wr_resp_rvalid", {31'b0, bus.ls_rvalid_o}, 32'h1);
      chk("wr_resp_rdata", bus.ls_rdata_o, 32'h0);
      chk("wr_resp_err", {31'b0, bus.ls_err_o}, 32'h0);
      ls_write(32'h10, 32'h1122_3344, 4'b0101);
      tick();
      ls_read(32'h10);
      tick();
      idle();
      chk("be_rvalid", {31'b0, bus.ls_rvalid_o}, 32'h1);
      chk("be_rdata", bus.ls_rdata_o, 32'hDE22_BE44);
      chk("be_if_rdata", bus.if_rdata_o, 32'h0);
      tick();
      chk("be_rvalid_drop", {31'b0, bus.ls_rvalid_o}, 32'h0);
      chk("be_rdata_zero", bus.ls_rdata_o, 32'h0);

      // Preload words 0 and 1, then read-after-write back to back
      ls_write(32'h0, 32'h1234_5678, 4'hF);
      tick();
      ls_write(32'h4, 32'hA5A5_0001, 4'hF);
      tick();
      ls_read(32'h4);
      tick();
      idle();
      chk("raw_rdata", bus.ls_rdata_o, 32'hA5A5_0001);

      // Collision
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0;
      ls_read(32'h4);
      #1;
      chk("col_n_gnt", {30'b0, bus.if_gnt_o, bus.ls_gnt_o}, 32'h1);
      tick();
      bus.ls_req_i = 1'b0;
      #1;
      chk("col_n1_gnt", {30'b0, bus.if_gnt_o, bus.ls_gnt_o}, 32'h2);
      chk("col_n1_ls_rvalid", {31'b0, bus.ls_rvalid_o}, 32'h1);
      chk("col_n1_ls_rdata", bus.ls_rdata_o, 32'hA5A5_0001);
      tick();
      bus.if_req_i = 1'b0;
      chk("col_n2_if_rvalid", {31'b0, bus.if_rvalid_o}, 32'h1);
      chk("col_n2_if_rdata", bus.if_rdata_o, 32'h1234_5678);
      chk("col_n2_ls_rvalid", {31'b0, bus.ls_rvalid_o}, 32'h0);
      tick();

      // Fairness under permanent contention
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0;
      ls_read(32'h4);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("fair_gnt_%0d", i), {30'b0, bus.if_gnt_o, bus.ls_gnt_o},
             (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         chk($sformatf("fair_rvalid_%0d", i), {30'b0, bus.if_rvalid_o, bus.ls_rvalid_o},
             (i % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("fair_rdata_%0d", i), bus.if_rdata_o | bus.ls_rdata_o,
             (i % 2 == 0) ? 32'hA5A5_0001 : 32'h1234_5678);
      end
      idle();
      tick();

      // Bounds / aliasing
      ls_write(32'h4000, 32'hCAFE_F00D, 4'hF);
      tick();
      chk("bnd_wr_rvalid", {31'b0, bus.ls_rvalid_o}, 32'h1);
      chk("bnd_wr_err", {31'b0, bus.ls_err_o}, {31'b0, BND_ERR});
      ls_read(32'h0);
      tick();
      idle();
      chk("bnd_rd_err", {31'b0, bus.ls_err_o}, 32'h0);
      chk("bnd_rd_word0", bus.ls_rdata_o, WORD0_EXP);
      tick();

      // Reset mid-access: the granted read must never respond
      ls_read(32'h0);
      #1;
      chk("mid_gnt", {31'b0, bus.ls_gnt_o}, 32'h1);
      #2;
      n_rst_i = 1'b0;
      #1;
      idle();
      tick();
      chk("mid_rvalid_in_rst", {31'b0, bus.ls_rvalid_o}, 32'h0);
      #2;
      n_rst_i = 1'b1;
      tick();
      chk("mid_rvalid_after", {30'b0, bus.if_rvalid_o, bus.ls_rvalid_o}, 32'h0);

      // Contents survive reset; starve cleared so LSU wins the first collision
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h4;
      ls_read(32'h0);
      #1;
      chk("post_rst_gnt", {30'b0, bus.if_gnt_o, bus.ls_gnt_o}, 32'h1);
      tick();
      idle();
      chk("post_rst_word0", bus.ls_rdata_o, WORD0_EXP);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/ram_arb_dp.md
Name: ram_arb_dp

Overview:
- Parametrised successor of the single-port data RAM.
- Serves two requesters, instruction fetch (IF, read-only) and load/store unit (LSU, read/write), from one single-ported storage array.
- Uses req/gnt handshakes, starvation-free arbitration, registered read with 1-cycle latency and per-byte write strobes of configurable width.
- Sits between core fetch/LSU and the on-chip memory map.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8. BE_W = DATA_W/8 (derived localparam).
- DEPTH, 4096, number of words; power of two, >= 2.
- ADDR_W, 32, byte-address width of both ports.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  asynchronous active-low reset
- if_req_i  in  1  IF read request
- if_addr_i  in  ADDR_W  IF byte address
- if_gnt_o  out  1  IF request accepted this cycle (combinational)
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  DATA_W  IF read data
- if_err_o  out  1  IF access error, qualified by if_rvalid_o
- ls_req_i  in  1  LSU request
- ls_we_i  in  1  1 = write, 0 = read
- ls_be_i  in  BE_W  byte enables (bit k -> data[8k+7:8k])
- ls_addr_i  in  ADDR_W  LSU byte address
- ls_wdata_i  in  DATA_W  LSU write data
- ls_gnt_o  out  1  LSU request accepted this cycle (combinational)
- ls_rvalid_o  out  1  LSU response valid (reads and writes)
- ls_rdata_o  out  DATA_W  LSU read data
- ls_err_o  out  1  LSU access error, qualified by ls_rvalid_o

Behaviour:
- Clock and reset: single clock clk_i; n_rst_i is asynchronous, active-low. While low: all rvalid, err and rdata outputs = 0, starve flag = 0. Array contents are not reset.
- Word index = addr[$clog2(BE_W) +: $clog2(DEPTH)]. Low $clog2(BE_W) bits are ignored (no misalign handling).
- Arbitration, one access per cycle:
  - Only one port requesting: that port is granted.
  - Both requesting: LSU is granted unless starve = 1, in which case IF is granted.
  - starve <= 1 when if_req_i & ~if_gnt_o; starve <= 0 when if_gnt_o. Under permanent contention, grants alternate.
  - gnt is never asserted without the matching req.
- Handshake: a request is accepted in the cycle where req & gnt. The requester must hold address/data stable until granted. Ungranted requests may be withdrawn.
- Write (granted LSU with ls_we_i = 1): bytes with ls_be_i[k] = 1 are updated at the end of the grant cycle; other bytes are unchanged. be = 0 is a legal no-op write.
- Read latency: a granted access in cycle N gives rvalid = 1 in cycle N+1 for exactly one cycle.
  - Read: rdata = array content as of the end of cycle N.
  - LSU write: ls_rvalid_o pulses in N+1 as a completion with ls_rdata_o = 0.
- rdata outputs are 0 whenever the corresponding rvalid = 0.
- Back-to-back: a grant every cycle gives rvalid every cycle. A read in N+1 of a word written in N returns the new data.
- Reset mid-operation: a grant in cycle N followed by reset assertion before the N+1 edge gives no rvalid; a write whose edge was already taken is retained.
- err outputs are 0 unless the optional feature is compiled in.

Optional Feature:
- Macro RAM_BOUNDS_CHECK_EN.
- Defined:
  - Any granted access with byte address >= DEPTH*BE_W is out of range.
  - Out-of-range writes are dropped (array unchanged).
  - Out-of-range reads return rdata = 0.
  - In both cases the response cycle has rvalid = 1 and err = 1.
- Undefined:
  - Upper address bits are ignored and addresses alias modulo DEPTH words.
  - err outputs are tied 0.

Test Plan:
- Reset check: hold n_rst_i low for 3 cycles, then release -> all rvalid/err/rdata = 0, and the first IF-only request is granted immediately.
- Byte enables: LSU write 0xDEADBEEF to 0x10 with be = 4'hF, then write 0x11223344 with be = 4'b0101, then read 0x10 -> ls_rvalid_o one cycle after the read grant, ls_rdata_o = 0xDE22BE44, if_rdata_o = 0.
- Collision: cycle N both req (IF 0x0, LSU read 0x4) -> ls_gnt_o = 1, if_gnt_o = 0; cycle N+1 if_gnt_o = 1 and ls_rvalid_o = 1; cycle N+2 if_rvalid_o = 1.
- Fairness: both ports requesting continuously for 8 cycles -> grants alternate LSU, IF, LSU, IF... (4 each), with each rvalid one cycle after its grant.
- Bounds: LSU write 0xCAFEF00D to 0x4000 (DEPTH = 4096), then read 0x0.
  - With the macro: the write response has ls_err_o = 1 and word 0 is unchanged.
  - Without the macro: err = 0 and the read of 0x0 returns 0xCAFEF00D.
- Reset mid-access: grant an LSU read in cycle N, assert n_rst_i asynchronously during N -> ls_rvalid_o stays 0 and no response is issued after release.
